// File: rtl/pulse_to_press.sv
// Converts single-cycle request pulses into press/gap waveforms on a registered press level.
// Requests that arrive while a press is under way are queued in a saturating pending counter.
module pulse_to_press #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned MAX_PENDING = 7,
  parameter int unsigned PW          = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_pulse,
  output logic          press,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          dropped
);

  localparam int unsigned TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  // The timer holds the number of cycles remaining after the current one, so zero marks the last cycle.
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          dropped_q, dropped_d;
  logic          press_q, press_d;
  logic          start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      pending_q <= '0;
      dropped_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
      press_q   <= press_d;
    end
  end

  always_comb begin
    start = ((state_q == IDLE) || ((state_q == GAP) && (timer_q == '0)))
            && ((pending_q != '0) || in_pulse);

    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PRESS;
          timer_d = HOLD_LOAD;
        end
      end
      PRESS: begin
        if (timer_q == '0) begin
          state_d = GAP;
          timer_d = GAP_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          if (start) begin
            state_d = PRESS;
            timer_d = HOLD_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // A same-cycle request may itself be the one consumed by start, leaving the count unchanged.
    pending_d = pending_q;
    dropped_d = 1'b0;
    if (in_pulse && !start) begin
      if (pending_q == PEND_MAX) begin
        dropped_d = 1'b1;
      end else begin
        pending_d = pending_q + PW'(1);
      end
    end else if (!in_pulse && start) begin
      pending_d = pending_q - PW'(1);
    end
  end

  always_comb begin
    press_d = (state_d == PRESS);
    press   = press_q;
    dropped = dropped_q;
    pending = pending_q;
    busy    = (state_q != IDLE) || (pending_q != '0);
  end

endmodule
